// File: rtl/var_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : var_table_pkg
//  Description : Shared constants and types for the variable table bank:
//                default address widths, write-mode encodings and the
//                thread-clear FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package var_table_pkg;

    localparam int c_VAR_ADDR_WIDTH  = 11;
    localparam int c_THREAD_ID_WIDTH = 4;
    localparam int c_CLUSTER_SIZE    = 40;
    localparam int c_ADDR_WIDTH      = c_THREAD_ID_WIDTH + c_VAR_ADDR_WIDTH;

    // Runtime write modes
    localparam logic c_WR_MODE_STORE  = 1'b0;
    localparam logic c_WR_MODE_TOGGLE = 1'b1;

    // Thread-clear sequencer states
    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/var_table_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : var_table_bank_if
//  Description : Runtime request bus of the variable table bank: request
//                handshake, common write port, per-replica read addresses
//                and read results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface var_table_bank_if #(
    parameter int ADDR_WIDTH   = var_table_pkg::c_ADDR_WIDTH,
    parameter int CLUSTER_SIZE = var_table_pkg::c_CLUSTER_SIZE
);
    logic                               req_valid_i;
    logic                               req_ready_o;
    logic                               wr_en_i;
    logic                               wr_mode_i;
    logic [ADDR_WIDTH-1:0]              wr_addr_i;
    logic                               wr_data_i;
    logic [CLUSTER_SIZE*ADDR_WIDTH-1:0] rd_addr_mi;
    logic [CLUSTER_SIZE-1:0]            rd_data_mo;
    logic                               rd_valid_o;

    modport master (
        output req_valid_i, wr_en_i, wr_mode_i, wr_addr_i, wr_data_i, rd_addr_mi,
        input  req_ready_o, rd_data_mo, rd_valid_o
    );

    modport slave (
        input  req_valid_i, wr_en_i, wr_mode_i, wr_addr_i, wr_data_i, rd_addr_mi,
        output req_ready_o, rd_data_mo, rd_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/var_table_replica.sv
`default_nettype none
// ============================================================================
//  Module      : var_table_replica
//  Description : One 1-bit-wide RAM with one write port (store or toggle)
//                and one asynchronous read port. Read-first on a same-cycle
//                address match unless VTB_WR_FORWARD_EN is defined, in which
//                case the value being written is forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module var_table_replica
    import var_table_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic                  i_wmode,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic                  i_wdata,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                       o_rdata
);
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic r_mem [c_DEPTH];
    logic w_wr_bit;

    // Toggle mode flips the stored bit; store mode takes the input bit.
    assign w_wr_bit = (i_wmode == c_WR_MODE_TOGGLE) ? ~r_mem[i_waddr] : i_wdata;

    // Storage is deliberately not reset so contents survive rst_ni.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= w_wr_bit;
        end
    end

`ifdef VTB_WR_FORWARD_EN
    assign o_rdata = (i_we && (i_raddr == i_waddr)) ? w_wr_bit : r_mem[i_raddr];
`else
    assign o_rdata = r_mem[i_raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/var_table_bank.sv
`default_nettype none
// ============================================================================
//  Module      : var_table_bank
//  Description : Bank of CLUSTER_SIZE bit-identical 1-bit variable tables
//                with one common write port, per-replica read ports, host
//                access with priority and a per-thread clear sequencer.
//                Optional macro VTB_WR_FORWARD_EN: same-cycle read of the
//                write address returns the post-write value.
//  Revision    : 1.0 - initial release
// ============================================================================
module var_table_bank
    import var_table_pkg::*;
#(
    parameter int VARIABLE_ADDRESS_WIDTH = c_VAR_ADDR_WIDTH,
    parameter int THREAD_ID_WIDTH        = c_THREAD_ID_WIDTH,
    parameter int CLUSTER_SIZE           = c_CLUSTER_SIZE
) (
    input  wire logic                                        clk_i,
    input  wire logic                                        rst_ni,
    input  wire logic                                        axi_en_i,
    input  wire logic                                        axi_wr_en_i,
    input  wire logic [THREAD_ID_WIDTH+VARIABLE_ADDRESS_WIDTH-1:0] axi_addr_i,
    input  wire logic                                        axi_data_i,
    output logic                                             axi_data_o,
    input  wire logic                                        clr_start_i,
    input  wire logic [THREAD_ID_WIDTH-1:0]                  clr_tid_i,
    output logic                                             clr_busy_o,
    output logic                                             clr_done_o,
    var_table_bank_if.slave                                  bus
);
    localparam int c_AW = THREAD_ID_WIDTH + VARIABLE_ADDRESS_WIDTH;

    clr_state_t                        r_state;
    logic [VARIABLE_ADDRESS_WIDTH-1:0] r_count;
    logic [THREAD_ID_WIDTH-1:0]        r_tid;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_rd_valid;
    logic [CLUSTER_SIZE-1:0]           r_rd_data;
    logic                              r_axi_data;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_we;
    logic                    w_wmode;
    logic [c_AW-1:0]         w_waddr;
    logic                    w_wdata;
    logic [CLUSTER_SIZE-1:0] w_rd;

    // Host traffic and an active sweep both lock out runtime requests.
    assign w_ready  = !axi_en_i && (r_state != CLR_CLEAR);
    assign w_accept = bus.req_valid_i && w_ready;

    // Single write port shared by sweep, host and runtime, in that priority.
    always_comb begin
        w_we    = 1'b0;
        w_wmode = c_WR_MODE_STORE;
        w_waddr = '0;
        w_wdata = 1'b0;
        if (r_state == CLR_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = {r_tid, r_count};
        end else if (axi_en_i && axi_wr_en_i) begin
            w_we    = 1'b1;
            w_waddr = axi_addr_i;
            w_wdata = axi_data_i;
        end else if (w_accept && bus.wr_en_i) begin
            w_we    = 1'b1;
            w_wmode = bus.wr_mode_i;
            w_waddr = bus.wr_addr_i;
            w_wdata = bus.wr_data_i;
        end
    end

    for (genvar gi = 0; gi < CLUSTER_SIZE; gi++) begin : g_replica
        logic [c_AW-1:0] w_raddr;
        if (gi == 0) begin : g_host_shared
            // Replica 0 serves host reads; runtime is stalled whenever host is active.
            assign w_raddr = axi_en_i ? axi_addr_i : bus.rd_addr_mi[0 +: c_AW];
        end else begin : g_runtime_only
            assign w_raddr = bus.rd_addr_mi[gi*c_AW +: c_AW];
        end

        var_table_replica #(
            .ADDR_WIDTH (c_AW)
        ) u_replica (
            .clk     (clk_i),
            .i_we    (w_we),
            .i_wmode (w_wmode),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (w_raddr),
            .o_rdata (w_rd[gi])
        );
    end

    // Runtime read results: captured on accept and held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_accept;
            if (w_accept) begin
                r_rd_data <= w_rd;
            end
        end
    end

    // Host read data; a thread being swept reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_axi_data <= 1'b0;
        end else if (axi_en_i && !axi_wr_en_i) begin
            r_axi_data <= (r_state == CLR_CLEAR) ? 1'b0 : w_rd[0];
        end
    end

    // Thread-clear sequencer: sweeps every variable of the latched thread.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= CLR_IDLE;
            r_count <= '0;
            r_tid   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    if (clr_start_i) begin
                        r_tid   <= clr_tid_i;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CLR_CLEAR;
                    end
                end
                CLR_CLEAR: begin
                    r_count <= r_count + VARIABLE_ADDRESS_WIDTH'(1);
                    if (r_count == '1) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= CLR_DONE;
                    end
                end
                CLR_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= CLR_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= CLR_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.rd_valid_o  = r_rd_valid;
    assign bus.rd_data_mo  = r_rd_data;
    assign axi_data_o      = r_axi_data;
    assign clr_busy_o      = r_busy;
    assign clr_done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_var_table_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_var_table_bank
//  Description : Self-checking bench for var_table_bank. Runtime read
//                results are predicted from a bit model when requests are
//                driven and compared when rd_valid_o is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_var_table_bank;
    localparam int AW = 15;
    localparam int CS = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          axi_en, axi_wr_en, axi_wdata, axi_rdata;
    logic [AW-1:0] axi_addr;
    logic          clr_start, clr_busy, clr_done;
    logic [3:0]    clr_tid;

    always #5 clk = ~clk;

    var_table_bank_if #(.ADDR_WIDTH(AW), .CLUSTER_SIZE(CS)) bus ();

    var_table_bank #(
        .VARIABLE_ADDRESS_WIDTH (11),
        .THREAD_ID_WIDTH        (4),
        .CLUSTER_SIZE           (CS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .axi_en_i    (axi_en),
        .axi_wr_en_i (axi_wr_en),
        .axi_addr_i  (axi_addr),
        .axi_data_i  (axi_wdata),
        .axi_data_o  (axi_rdata),
        .clr_start_i (clr_start),
        .clr_tid_i   (clr_tid),
        .clr_busy_o  (clr_busy),
        .clr_done_o  (clr_done),
        .bus         (bus)
    );

    typedef struct {
        int            due;
        logic [CS-1:0] data;
    } sb_t;

    sb_t sb[$];
    bit  model [32768];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each expected result must appear exactly on its due cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                checks++;
                if (bus.rd_valid_o !== 1'b1 || bus.rd_data_mo !== sb[0].data) begin
                    errors++;
                    $display("FAIL rd_result cyc=%0d: valid=%b data=%h, required valid=1 data=%h",
                             cyc, bus.rd_valid_o, bus.rd_data_mo, sb[0].data);
                end
                void'(sb.pop_front());
            end else if (bus.rd_valid_o !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected cyc=%0d: valid=%b, required 0", cyc, bus.rd_valid_o);
            end
        end
    end

    function automatic logic [CS*AW-1:0] fill_all(input logic [AW-1:0] a);
        logic [CS*AW-1:0] r;
        for (int i = 0; i < CS; i++) r[i*AW +: AW] = a;
        return r;
    endfunction

    function automatic logic [AW-1:0] taddr(input int t, input int v);
        return {4'(t), 11'(v)};
    endfunction

    task automatic rt_req(input logic we, input logic mode, input logic [AW-1:0] wa,
                          input logic wd, input logic [CS*AW-1:0] ra);
        sb_t e;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.wr_en_i     = we;
        bus.wr_mode_i   = mode;
        bus.wr_addr_i   = wa;
        bus.wr_data_i   = wd;
        bus.rd_addr_mi  = ra;
        for (int i = 0; i < CS; i++) begin
            logic [AW-1:0] a;
            a = ra[i*AW +: AW];
            e.data[i] = model[a];
`ifdef VTB_WR_FORWARD_EN
            if (we && a == wa) e.data[i] = mode ? ~model[wa] : wd;
`endif
        end
        if (we) model[wa] = mode ? ~model[wa] : wd;
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic rt_idle();
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.wr_en_i     = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic d);
        @(negedge clk);
        axi_en = 1'b1; axi_wr_en = 1'b1; axi_addr = a; axi_wdata = d;
        model[a] = d;
        @(negedge clk);
        axi_en = 1'b0; axi_wr_en = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic v);
        @(negedge clk);
        axi_en = 1'b1; axi_wr_en = 1'b0; axi_addr = a;
        @(negedge clk);
        axi_en = 1'b0;
        v = axi_rdata;
    endtask

    task automatic test_reset();
        axi_en = 0; axi_wr_en = 0; axi_addr = '0; axi_wdata = 0;
        clr_start = 0; clr_tid = '0;
        bus.req_valid_i = 0; bus.wr_en_i = 0; bus.wr_mode_i = 0;
        bus.wr_addr_i = '0; bus.wr_data_i = 0; bus.rd_addr_mi = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, required 0", bus.rd_valid_o); end
        checks++; if (bus.rd_data_mo !== '0) begin errors++; $display("FAIL reset_rd_data: got %h, required 0", bus.rd_data_mo); end
        checks++; if (axi_rdata !== 1'b0) begin errors++; $display("FAIL reset_axi_data: got %b, required 0", axi_rdata); end
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", clr_busy); end
        checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", clr_done); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.req_ready_o); end
    endtask

    task automatic test_host_write_read();
        logic v;
        host_write(15'h012, 1'b1);
        rt_req(1'b0, 1'b0, '0, 1'b0, fill_all(15'h012));
        rt_idle();
        wait_drain();
        host_read(15'h012, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL host_read_012: got %b, required 1", v); end
    endtask

    task automatic test_toggle();
        logic v;
        host_write(15'h7FF, 1'b0);
        rt_req(1'b1, 1'b1, 15'h7FF, 1'b0, fill_all(15'h012));
        rt_req(1'b0, 1'b0, '0, 1'b0, fill_all(15'h7FF));
        rt_req(1'b1, 1'b1, 15'h7FF, 1'b0, fill_all(15'h012));
        rt_req(1'b0, 1'b0, '0, 1'b0, fill_all(15'h7FF));
        rt_idle();
        wait_drain();
        host_read(15'h7FF, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL toggle_final: got %b, required 0", v); end
    endtask

    task automatic test_same_cycle();
        host_write(15'h100, 1'b0);
        rt_req(1'b1, 1'b0, 15'h100, 1'b1, fill_all(15'h100));
        rt_req(1'b0, 1'b0, '0, 1'b0, fill_all(15'h100));
        rt_idle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [CS*AW-1:0] ra;
        for (int k = 0; k < 8; k++) begin
            rt_req(1'b1, 1'b0, AW'(32'h200 + k), 1'(k ^ (k >> 1)),
                   (k == 0) ? fill_all(15'h012) : fill_all(AW'(32'h200 + k - 1)));
        end
        for (int i = 0; i < CS; i++) ra[i*AW +: AW] = AW'(32'h200 + (i % 8));
        rt_req(1'b0, 1'b0, '0, 1'b0, ra);
        rt_req(1'b1, 1'b1, 15'h203, 1'b0, ra);
        rt_req(1'b0, 1'b0, '0, 1'b0, ra);
        rt_idle();
        wait_drain();
    endtask

    task automatic test_host_priority();
        @(negedge clk);
        axi_en = 1'b1; axi_wr_en = 1'b0; axi_addr = 15'h012;
        bus.req_valid_i = 1'b1; bus.wr_en_i = 1'b0; bus.rd_addr_mi = fill_all(15'h012);
        #1;
        checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b, required 0", bus.req_ready_o); end
        @(negedge clk);
        axi_en = 1'b0; bus.req_valid_i = 1'b0;
        checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL prio_rd_valid: got %b, required 0", bus.rd_valid_o); end
        checks++; if (axi_rdata !== 1'b1) begin errors++; $display("FAIL prio_axi_data: got %b, required 1", axi_rdata); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [CS*AW-1:0] ra3, ra4;
        logic v;
        for (int t = 3; t <= 4; t++)
            for (int a = 0; a < 2048; a++)
                rt_req(1'b1, 1'b0, taddr(t, a), 1'b1, fill_all(15'h012));
        rt_idle();
        wait_drain();
        @(negedge clk);
        clr_start = 1'b1; clr_tid = 4'd3;
        @(negedge clk);
        clr_start = 1'b0;
        for (int c = 0; c < 2200; c++) begin
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
            case (c)
                3: begin
                    checks++;
                    if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b, required 0", bus.req_ready_o); end
                end
                5:  begin clr_start = 1'b1; clr_tid = 4'd4; end
                6:  clr_start = 1'b0;
                10: begin axi_en = 1'b1; axi_wr_en = 1'b1; axi_addr = taddr(3, 0); axi_wdata = 1'b1; end
                11: begin axi_en = 1'b0; axi_wr_en = 1'b0; end
                20: begin axi_en = 1'b1; axi_wr_en = 1'b0; axi_addr = taddr(4, 16); end
                21: begin
                    axi_en = 1'b0;
                    checks++;
                    if (axi_rdata !== 1'b0) begin errors++; $display("FAIL clear_host_read: got %b, required 0", axi_rdata); end
                end
                default: ;
            endcase
            @(negedge clk);
        end
        checks++; if (busy_cnt != 2048) begin errors++; $display("FAIL clear_busy_cycles: got %0d, required 2048", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clear_done_pulses: got %0d, required 1", done_cnt); end
        checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL clear_ready_after: got %b, required 1", bus.req_ready_o); end
        for (int a = 0; a < 2048; a++) model[taddr(3, a)] = 1'b0;
        for (int i = 0; i < CS; i++) begin
            ra3[i*AW +: AW] = taddr(3, i * 51 + (i == 39 ? 58 : 0));
            ra4[i*AW +: AW] = taddr(4, i * 51);
        end
        ra3[39*AW +: AW] = taddr(3, 2047);
        rt_req(1'b0, 1'b0, '0, 1'b0, ra3);
        rt_req(1'b0, 1'b0, '0, 1'b0, ra4);
        rt_idle();
        wait_drain();
        host_read(taddr(3, 0), v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL clear_thread3_addr0: got %b, required 0", v); end
    endtask

    task automatic test_reset_mid_clear();
        int done_cnt = 0;
        logic [CS*AW-1:0] ra;
        @(negedge clk);
        clr_start = 1'b1; clr_tid = 4'd4;
        @(negedge clk);
        clr_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (clr_done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL midclr_busy_before: got %b, required 1", clr_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL midclr_busy_async: got %b, required 0", clr_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (clr_done === 1'b1 || clr_busy === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL midclr_no_done: got %0d activity cycles, required 0", done_cnt); end
        for (int a = 0; a < 100; a++) model[taddr(4, a)] = 1'b0;
        ra = fill_all(taddr(4, 1024));
        ra[0 +: AW]  = taddr(4, 99);
        ra[AW +: AW] = taddr(4, 100);
        ra[2*AW +: AW] = taddr(3, 500);
        rt_req(1'b0, 1'b0, '0, 1'b0, ra);
        rt_idle();
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_write_read();
        test_toggle();
        test_same_cycle();
        test_back_to_back();
        test_host_priority();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/var_table_bank.md
VAR_TABLE_BANK -- requirements
Module: var_table_bank

Interface
REQ-001 SHALL have parameter VARIABLE_ADDRESS_WIDTH, default 11, meaning variable index width.
REQ-002 SHALL have parameter THREAD_ID_WIDTH, default 4, meaning thread index width.
REQ-003 SHALL have parameter CLUSTER_SIZE, default 40, meaning number of read replicas (read ports).
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, meaning the asynchronous active-low reset.
REQ-006 SHALL have ports axi_en_i / axi_wr_en_i, input, 1 each, meaning host access enable and write qualifier.
REQ-007 SHALL have ports axi_addr_i, input, THREAD_ID_WIDTH+VARIABLE_ADDRESS_WIDTH, and axi_data_i, input, 1, meaning the host address and write bit.
REQ-008 SHALL have port axi_data_o, input-registered output, 1, meaning host read data.
REQ-009 SHALL have ports req_valid_i, input, 1, and req_ready_o, output, 1, meaning the runtime request handshake.
REQ-010 SHALL have port wr_en_i, input, 1, and wr_mode_i, input, 1 (0=store, 1=toggle), meaning the runtime write qualifiers.
REQ-011 SHALL have ports wr_addr_i, input, THREAD_ID_WIDTH+VARIABLE_ADDRESS_WIDTH, and wr_data_i, input, 1, meaning the common write address and data.
REQ-012 SHALL have port rd_addr_mi, input, CLUSTER_SIZE*(THREAD_ID_WIDTH+VARIABLE_ADDRESS_WIDTH), meaning the packed per-replica read addresses, replica i at slice i.
REQ-013 SHALL have ports rd_data_mo, output, CLUSTER_SIZE, and rd_valid_o, output, 1, meaning the read results and their qualifier.
REQ-014 SHALL have ports clr_start_i, input, 1, clr_tid_i, input, THREAD_ID_WIDTH, clr_busy_o, output, 1, and clr_done_o, output, 1, meaning the thread-clear control.

Function
REQ-015 SHALL keep all CLUSTER_SIZE replicas bit-identical; every write updates all replicas at one address in the same cycle.
REQ-016 SHALL accept a runtime request when req_valid_i && req_ready_o; rd_data_mo/rd_valid_o appear exactly 1 cycle later; rd_valid_o pulses 1 cycle per accepted request.
REQ-017 SHALL, in an accepted request with wr_en_i=1, write wr_data_i (mode 0) or invert the stored bit (mode 1) at wr_addr_i.
REQ-018 SHALL, when a read address equals the same-cycle write address, return the pre-write value (read-first).
REQ-019 SHALL give host access priority: req_ready_o=0 in any cycle with axi_en_i=1; host read data appears on axi_data_o 1 cycle later.
REQ-020 SHALL run clear FSM IDLE->CLEAR->DONE->IDLE: clr_start_i in IDLE latches clr_tid_i, zeroes counter.
REQ-021 SHALL, in CLEAR, write 0 to {tid, counter} each cycle, increment counter, leave CLEAR after counter reaches 2^VARIABLE_ADDRESS_WIDTH-1 (exactly 2^VARIABLE_ADDRESS_WIDTH cycles, counter wraps to 0).
REQ-022 SHALL hold clr_busy_o=1 and req_ready_o=0 in CLEAR; host writes are ignored and host reads return 0 in CLEAR.
REQ-023 SHALL pulse clr_done_o for the single DONE cycle; clr_start_i outside IDLE is ignored.
REQ-024 SHALL not corrupt addresses of threads other than the cleared one.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously force FSM=IDLE, counter=0, rd_valid_o=0, rd_data_mo=0, axi_data_o=0, clr_busy_o=0, clr_done_o=0; req_ready_o=1 after release when axi_en_i=0.
REQ-026 SHALL not reset storage contents; reset mid-CLEAR abandons the sweep with no done pulse.

Configuration
REQ-027 SHALL, with VTB_WR_FORWARD_EN defined, return the post-write value for same-cycle read/write address matches; without it, REQ-018 applies.

Structure
REQ-028 SHALL place FSM state enum, wr_mode encodings and address-width localparams in shared package var_table_pkg.
REQ-029 SHALL instantiate sub-module var_table_replica (one 1-bit RAM with one read and one write port) CLUSTER_SIZE times.

Verification
REQ-030 SHALL cover: host write 1 to 0x012 then runtime read 0x012 on all replicas -> rd_data_mo all ones, rd_valid_o 1 cycle after accept.
REQ-031 SHALL cover: toggle-mode write twice at 0x7FF (init 0) -> reads return 1, then 0.
REQ-032 SHALL cover: write 1 and read same address 0x100 in one cycle -> 0 without macro, 1 with VTB_WR_FORWARD_EN.
REQ-033 SHALL cover: clr_start_i with tid 3 after filling threads 3 and 4 with ones -> clr_busy_o for 2048 cycles, clr_done_o one pulse, thread 3 reads 0, thread 4 reads 1.
REQ-034 SHALL cover: axi_en_i=1 with req_valid_i=1 -> req_ready_o=0, no rd_valid_o; rst_ni low at cycle 100 of CLEAR -> busy drops asynchronously, no done.
